// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq : sequential ALU with single-cycle operations and a bit-serial
//           shift-add multiplier.
//
// Ports
//   clk      in   clock, all state on the rising edge
//   rst_n    in   asynchronous active-low reset
//   start    in   operation request, accepted only while idle
//   oper     in   4-bit opcode (1 ADD .. 13 SHR, 0/14/15 illegal)
//   A_bus    in   operand A
//   B_bus    in   operand B
//   C_bus    out  registered result
//   Z_flag   out  result == 0 (forced 0 for illegal opcodes)
//   N_flag   out  result MSB
//   CY_flag  out  carry (ADD/INCAC) or borrow (SUB/DECAC)
//   V_flag   out  multiply produced nonzero upper half
//   busy     out  multiply in progress
//   done     out  one-cycle pulse when result and flags are updated
// -----------------------------------------------------------------------------
module alu_seq #(
    parameter int WIDTH = 24,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       oper,
    input  logic [WIDTH-1:0] A_bus,
    input  logic [WIDTH-1:0] B_bus,
    output logic [WIDTH-1:0] C_bus,
    output logic             Z_flag,
    output logic             N_flag,
    output logic             CY_flag,
    output logic             V_flag,
    output logic             busy,
    output logic             done
);

    localparam logic [3:0] OP_ADD    = 4'd1;
    localparam logic [3:0] OP_SUB    = 4'd2;
    localparam logic [3:0] OP_LSHFT1 = 4'd3;
    localparam logic [3:0] OP_LSHFT2 = 4'd4;
    localparam logic [3:0] OP_LSHFT8 = 4'd5;
    localparam logic [3:0] OP_RSHFT4 = 4'd6;
    localparam logic [3:0] OP_PASSA  = 4'd7;
    localparam logic [3:0] OP_PASSB  = 4'd8;
    localparam logic [3:0] OP_INCAC  = 4'd9;
    localparam logic [3:0] OP_DECAC  = 4'd10;
    localparam logic [3:0] OP_MUL    = 4'd11;
    localparam logic [3:0] OP_SHL    = 4'd12;
    localparam logic [3:0] OP_SHR    = 4'd13;

    // Variable shifts by this amount or more produce zero.
    localparam logic [WIDTH-1:0] SHIFT_LIM = WIDTH'(WIDTH);
    // Counter value on the edge that processes the final multiplier bit.
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(WIDTH - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    state_t                 state_reg;
    logic [WIDTH-1:0]       c_reg;
    logic                   z_reg;
    logic                   n_reg;
    logic                   cy_reg;
    logic                   v_reg;
    logic                   done_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic [2*WIDTH-1:0]     acc_reg;
    logic [2*WIDTH-1:0]     mcand_reg;
    logic [WIDTH-1:0]       mplier_reg;

    // ---------------------------------------------------------------------
    // Single-cycle datapath, evaluated on the live inputs at the accept edge
    // ---------------------------------------------------------------------
    logic [WIDTH-1:0] alu_res;
    logic             alu_cy;
    logic             alu_legal;
    logic [WIDTH:0]   sum_add;
    logic [WIDTH:0]   sum_inc;

    assign sum_add = {1'b0, A_bus} + {1'b0, B_bus};
    assign sum_inc = {1'b0, A_bus} + (WIDTH+1)'(1);

    always_comb begin
        alu_res   = '0;
        alu_cy    = 1'b0;
        alu_legal = 1'b1;
        case (oper)
            OP_ADD: begin
                alu_res = sum_add[WIDTH-1:0];
                alu_cy  = sum_add[WIDTH];
            end
            OP_SUB: begin
                alu_res = A_bus - B_bus;
                alu_cy  = (A_bus < B_bus);
            end
            OP_LSHFT1: alu_res = A_bus << 1;
            OP_LSHFT2: alu_res = A_bus << 2;
            OP_LSHFT8: alu_res = A_bus << 8;
            OP_RSHFT4: alu_res = A_bus >> 4;
            OP_PASSA:  alu_res = A_bus;
            OP_PASSB:  alu_res = B_bus;
            OP_INCAC: begin
                alu_res = sum_inc[WIDTH-1:0];
                alu_cy  = sum_inc[WIDTH];
            end
            OP_DECAC: begin
                alu_res = A_bus - WIDTH'(1);
                alu_cy  = (A_bus == '0);
            end
            OP_SHL: alu_res = (B_bus >= SHIFT_LIM) ? '0 : (A_bus << B_bus);
            OP_SHR: alu_res = (B_bus >= SHIFT_LIM) ? '0 : (A_bus >> B_bus);
            // MUL never commits through this path; it goes to the iterative unit.
            OP_MUL: alu_res = '0;
            default: alu_legal = 1'b0;
        endcase
    end

    // ---------------------------------------------------------------------
    // Shift-add multiplier: multiplicand shifts left, multiplier shifts
    // right, so bit 0 of the multiplier always selects the next partial
    // product.
    // ---------------------------------------------------------------------
    logic [2*WIDTH-1:0] addend;
    logic [2*WIDTH-1:0] acc_next;

    generate
        for (genvar gi = 0; gi < 2*WIDTH; gi++) begin : g_pp
            assign addend[gi] = mcand_reg[gi] & mplier_reg[0];
        end
    endgenerate

    assign acc_next = acc_reg + addend;

    // ---------------------------------------------------------------------
    // Control and result registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            c_reg      <= '0;
            z_reg      <= 1'b0;
            n_reg      <= 1'b0;
            cy_reg     <= 1'b0;
            v_reg      <= 1'b0;
            done_reg   <= 1'b0;
            cnt_reg    <= '0;
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        if (oper == OP_MUL) begin
                            state_reg  <= ST_MUL;
                            acc_reg    <= '0;
                            cnt_reg    <= '0;
                            mcand_reg  <= {{WIDTH{1'b0}}, A_bus};
                            mplier_reg <= B_bus;
                        end else begin
                            c_reg    <= alu_res;
                            // Illegal opcodes report all flags clear even though
                            // the result is zero.
                            z_reg    <= alu_legal && (alu_res == '0);
                            n_reg    <= alu_res[WIDTH-1];
                            cy_reg   <= alu_cy;
                            v_reg    <= 1'b0;
                            done_reg <= 1'b1;
                        end
                    end
                end
                ST_MUL: begin
                    // start is deliberately ignored here.
                    acc_reg    <= acc_next;
                    mcand_reg  <= mcand_reg << 1;
                    mplier_reg <= mplier_reg >> 1;
                    cnt_reg    <= cnt_reg + 1'b1;
                    if (cnt_reg == LAST_CNT) begin
                        state_reg <= ST_IDLE;
                        cnt_reg   <= '0;
                        c_reg     <= acc_next[WIDTH-1:0];
                        z_reg     <= (acc_next[WIDTH-1:0] == '0);
                        n_reg     <= acc_next[WIDTH-1];
                        cy_reg    <= 1'b0;
                        v_reg     <= |acc_next[2*WIDTH-1:WIDTH];
                        done_reg  <= 1'b1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign C_bus   = c_reg;
    assign Z_flag  = z_reg;
    assign N_flag  = n_reg;
    assign CY_flag = cy_reg;
    assign V_flag  = v_reg;
    assign done    = done_reg;
    assign busy    = (state_reg == ST_MUL);

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

    localparam int WIDTH = 24;
    localparam int CNT_W = 5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [3:0]       oper = 4'd0;
    logic [WIDTH-1:0] a_bus = '0;
    logic [WIDTH-1:0] b_bus = '0;
    logic [WIDTH-1:0] c_bus;
    logic             z_flag, n_flag, cy_flag, v_flag, busy, done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .oper   (oper),
        .A_bus  (a_bus),
        .B_bus  (b_bus),
        .C_bus  (c_bus),
        .Z_flag (z_flag),
        .N_flag (n_flag),
        .CY_flag(cy_flag),
        .V_flag (v_flag),
        .busy   (busy),
        .done   (done)
    );

    // ------------------------------------------------------------------
    // Reference model: results from plain wide arithmetic
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [WIDTH-1:0] c;
        logic z;
        logic n;
        logic cy;
        logic v;
    } res_t;

    function automatic res_t compute(input logic [3:0] op, input logic [WIDTH-1:0] a,
                                     input logic [WIDTH-1:0] b);
        logic [63:0] x, y, r;
        logic legal;
        res_t o;
        x = 64'(a);
        y = 64'(b);
        r = 64'd0;
        legal = 1'b1;
        o = '0;
        case (op)
            4'd1:  begin r = x + y; o.cy = r[WIDTH]; end
            4'd2:  begin r = x - y; o.cy = (x < y); end
            4'd3:  r = x << 1;
            4'd4:  r = x << 2;
            4'd5:  r = x << 8;
            4'd6:  r = x >> 4;
            4'd7:  r = x;
            4'd8:  r = y;
            4'd9:  begin r = x + 64'd1; o.cy = r[WIDTH]; end
            4'd10: begin r = x - 64'd1; o.cy = (x == 64'd0); end
            4'd11: begin r = x * y; o.v = ((r >> WIDTH) != 64'd0); end
            4'd12: r = (y >= 64'(WIDTH)) ? 64'd0 : (x << y);
            4'd13: r = (y >= 64'(WIDTH)) ? 64'd0 : (x >> y);
            default: legal = 1'b0;
        endcase
        o.c = r[WIDTH-1:0];
        o.z = legal && (o.c == '0);
        o.n = o.c[WIDTH-1];
        return o;
    endfunction

    res_t exp_r;
    res_t mul_pend;
    logic exp_busy;
    logic exp_done;
    int   mul_left;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_r    <= '0;
            exp_busy <= 1'b0;
            exp_done <= 1'b0;
            mul_left <= 0;
        end else begin
            exp_done <= 1'b0;
            if (mul_left > 0) begin
                mul_left <= mul_left - 1;
                if (mul_left == 1) begin
                    exp_r    <= mul_pend;
                    exp_done <= 1'b1;
                    exp_busy <= 1'b0;
                end
            end else if (start) begin
                if (oper == 4'd11) begin
                    mul_pend <= compute(oper, a_bus, b_bus);
                    mul_left <= WIDTH;
                    exp_busy <= 1'b1;
                end else begin
                    exp_r    <= compute(oper, a_bus, b_bus);
                    exp_done <= 1'b1;
                end
            end
        end
    end

    // Every-cycle comparison against the model
    initial begin
        forever begin
            @(posedge clk);
            #1;
            total++;
            if ({busy, done} !== {exp_busy, exp_done}) begin
                bad++;
                $display("FAIL ctrl t=%0t got busy=%b done=%b want busy=%b done=%b",
                         $time, busy, done, exp_busy, exp_done);
            end
            total++;
            if ({c_bus, z_flag, n_flag, cy_flag, v_flag} !== exp_r) begin
                bad++;
                $display("FAIL result t=%0t got c=%h z=%b n=%b cy=%b v=%b want c=%h z=%b n=%b cy=%b v=%b",
                         $time, c_bus, z_flag, n_flag, cy_flag, v_flag,
                         exp_r.c, exp_r.z, exp_r.n, exp_r.cy, exp_r.v);
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus with hand-computed expectations
    // ------------------------------------------------------------------
    task automatic lit(input string nm, input logic [WIDTH-1:0] c, input logic z,
                       input logic n, input logic cy, input logic v);
        res_t want;
        want = {c, z, n, cy, v};
        total++;
        if ({c_bus, z_flag, n_flag, cy_flag, v_flag} !== want) begin
            bad++;
            $display("FAIL %s got c=%h z=%b n=%b cy=%b v=%b want c=%h z=%b n=%b cy=%b v=%b",
                     nm, c_bus, z_flag, n_flag, cy_flag, v_flag, c, z, n, cy, v);
        end
        total++;
        if (exp_r !== want) begin
            bad++;
            $display("FAIL %s-model got c=%h z=%b n=%b cy=%b v=%b want c=%h z=%b n=%b cy=%b v=%b",
                     nm, exp_r.c, exp_r.z, exp_r.n, exp_r.cy, exp_r.v, c, z, n, cy, v);
        end
    endtask

    task automatic check_int(input string nm, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got %0d want %0d", nm, got, want);
        end
    endtask

    task automatic run_op(input logic [3:0] op, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b);
        int n;
        @(negedge clk);
        start = 1'b1; oper = op; a_bus = a; b_bus = b;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < WIDTH + 10) begin
            n++;
            @(negedge clk);
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL done-timeout op=%0d got done=0 want done=1", op);
        end
        $display("op=%0d a=%h b=%h -> c=%h z=%b n=%b cy=%b v=%b",
                 op, a, b, c_bus, z_flag, n_flag, cy_flag, v_flag);
    endtask

    // MUL with busy-cycle count; optionally injects an ADD mid-operation
    // and/or releases reset on the same edge start is first presented.
    task automatic mul_counted(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic inject, input logic rel_reset, output int nbusy);
        @(negedge clk);
        if (rel_reset) rst_n = 1'b1;
        start = 1'b1; oper = 4'd11; a_bus = a; b_bus = b;
        @(negedge clk);
        start = 1'b0;
        a_bus = '1; b_bus = '1;   // captured operands must not follow these
        nbusy = 0;
        while (busy && nbusy < 100) begin
            nbusy++;
            if (inject && nbusy == 10) begin
                start = 1'b1; oper = 4'd1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        total++;
        if (!done) begin
            bad++;
            $display("FAIL mul-done got done=%b want done=1", done);
        end
        $display("op=11 a=%h b=%h busy_cycles=%0d -> c=%h z=%b n=%b cy=%b v=%b",
                 a, b, nbusy, c_bus, z_flag, n_flag, cy_flag, v_flag);
    endtask

    initial begin
        int nb;
        int ndone;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset: everything stays zero
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++;
            if ({c_bus, z_flag, n_flag, cy_flag, v_flag, busy, done} !== '0) begin
                bad++;
                $display("FAIL idle cycle %0d got c=%h flags=%b%b%b%b busy=%b done=%b want all 0",
                         i, c_bus, z_flag, n_flag, cy_flag, v_flag, busy, done);
            end
        end

        run_op(4'd1, 24'hFFFFFF, 24'h000001);
        lit("add-wrap", 24'h000000, 1'b1, 1'b0, 1'b1, 1'b0);
        run_op(4'd2, 24'h000005, 24'h000007);
        lit("sub-borrow", 24'hFFFFFE, 1'b0, 1'b1, 1'b1, 1'b0);

        mul_counted(24'h001000, 24'h000010, 1'b1, 1'b0, nb);
        check_int("mul-busy-cycles", nb, 24);
        lit("mul-small", 24'h010000, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check_int("mul-single-done", int'(done), 0);

        run_op(4'd11, 24'h100000, 24'h000020);
        lit("mul-ovf", 24'h000000, 1'b1, 1'b0, 1'b0, 1'b1);
        run_op(4'd8, 24'h00AAAA, 24'h123456);
        lit("passb", 24'h123456, 1'b0, 1'b0, 1'b0, 1'b0);

        run_op(4'd12, 24'h000001, 24'd23);
        lit("shl-23", 24'h800000, 1'b0, 1'b1, 1'b0, 1'b0);
        run_op(4'd12, 24'h000001, 24'd30);
        lit("shl-30", 24'h000000, 1'b1, 1'b0, 1'b0, 1'b0);
        run_op(4'd6, 24'hABCDEF, 24'h000000);
        lit("rshft4", 24'h0ABCDE, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op(4'd15, 24'h123456, 24'h654321);
        lit("illegal", 24'h000000, 1'b0, 1'b0, 1'b0, 1'b0);

        run_op(4'd9, 24'hFFFFFF, 24'h000000);
        lit("inc-wrap", 24'h000000, 1'b1, 1'b0, 1'b1, 1'b0);
        run_op(4'd13, 24'h800000, 24'd24);
        lit("shr-24", 24'h000000, 1'b1, 1'b0, 1'b0, 1'b0);
        run_op(4'd13, 24'h800000, 24'd4);
        lit("shr-4", 24'h080000, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op(4'd5, 24'h12ABCD, 24'h000000);
        lit("lshft8", 24'hABCD00, 1'b0, 1'b1, 1'b0, 1'b0);

        // Back-to-back single-cycle ops, one accept per edge
        @(negedge clk);
        start = 1'b1; oper = 4'd3; a_bus = 24'h400001; b_bus = '0;
        ndone = 0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            ndone += int'(done);
            case (i)
                1: begin oper = 4'd4; a_bus = 24'h3FFFFF; end
                2: begin oper = 4'd7; a_bus = 24'h000000; end
                3: begin oper = 4'd0; a_bus = 24'h777777; end
                4: begin oper = 4'd2; a_bus = 24'h000009; b_bus = 24'h000004; end
                default: start = 1'b0;
            endcase
        end
        check_int("burst-dones", ndone, 5);
        lit("burst-last-sub", 24'h000005, 1'b0, 1'b0, 1'b0, 1'b0);

        run_op(4'd10, 24'h000000, 24'h000000);
        lit("dec-borrow", 24'hFFFFFF, 1'b0, 1'b1, 1'b1, 1'b0);

        // Reset in the middle of a multiply
        @(negedge clk);
        start = 1'b1; oper = 4'd11; a_bus = 24'h000005; b_bus = 24'h000007;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({c_bus, z_flag, n_flag, cy_flag, v_flag, busy, done} !== '0) begin
            bad++;
            $display("FAIL async-reset got c=%h flags=%b%b%b%b busy=%b done=%b want all 0",
                     c_bus, z_flag, n_flag, cy_flag, v_flag, busy, done);
        end
        $display("reset asserted mid-MUL -> c=%h busy=%b done=%b", c_bus, busy, done);
        repeat (2) @(negedge clk);

        mul_counted(24'h000003, 24'h000004, 1'b0, 1'b1, nb);
        check_int("mul-restart-busy", nb, 24);
        lit("mul-restart", 24'h00000C, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 24, datapath width in bits; legal range 8..32.
REQ-002 Parameter CNT_W, default 5, multiply iteration counter width; SHALL satisfy 2**CNT_W >= WIDTH.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  operation request, sampled on rising clk edge.
REQ-006 oper  input  4  opcode: 1 ADD, 2 SUB, 3 LSHFT1, 4 LSHFT2, 5 LSHFT8, 6 RSHFT4, 7 PASSATOC, 8 PASSBTOC, 9 INCAC, 10 DECAC, 11 MUL, 12 SHL (by B), 13 SHR (by B); 0,14,15 illegal.
REQ-007 A_bus  input  WIDTH  operand A.
REQ-008 B_bus  input  WIDTH  operand B.
REQ-009 C_bus  output  WIDTH  registered result.
REQ-010 Z_flag  output  1  registered zero flag.
REQ-011 N_flag  output  1  registered negative flag (C_bus MSB).
REQ-012 CY_flag  output  1  registered carry/borrow flag.
REQ-013 V_flag  output  1  registered multiply-overflow flag.
REQ-014 busy  output  1  high while multiply in progress.
REQ-015 done  output  1  one-cycle pulse, result and flags valid.

Function
REQ-016 States: IDLE, MUL; start accepted only when busy=0; start while busy=1 ignored, no effect on operands, result or flags.
REQ-017 Accept edge E0: oper, A_bus, B_bus captured; later input changes do not affect the operation.
REQ-018 Non-MUL op (incl. illegal): C_bus and flags written at E0; done=1 in cycle after E0; state stays IDLE; back-to-back start accepted every cycle.
REQ-019 MUL: at E0 state->MUL, busy=1, accumulator cleared, counter=0; one multiplier bit processed (shift-add) per edge E1..E_WIDTH; at E_WIDTH C_bus/flags written, done=1, busy=0, state->IDLE.
REQ-020 MUL result: C_bus = low WIDTH bits of unsigned A*B; V_flag=1 iff high WIDTH bits of full 2*WIDTH product nonzero.
REQ-021 ADD/INCAC: CY_flag = carry out of bit WIDTH-1; SUB/DECAC: CY_flag = borrow (1 iff minuend < subtrahend, unsigned); all other ops CY_flag=0.
REQ-022 V_flag=0 for all ops except MUL.
REQ-023 Z_flag = (result == 0) and N_flag = result[WIDTH-1], updated on every completed op (not only SUB).
REQ-024 Fixed shifts logical, zero-fill; SHL/SHR shift A by unsigned B_bus value; amount >= WIDTH gives 0.
REQ-025 Illegal opcode: C_bus=0, all flags 0, done pulses normally.
REQ-026 C_bus and flags hold last completed value between operations; not changed during MUL iterations.
REQ-027 done high exactly one cycle per accepted operation; never asserted without a prior accept.

Reset
REQ-028 rst_n low asynchronously forces: state IDLE, C_bus=0, Z_flag=0, N_flag=0, CY_flag=0, V_flag=0, busy=0, done=0, counter=0.
REQ-029 Reset mid-MUL aborts operation; no done pulse produced for aborted operation; first start after rst_n high accepted normally.
REQ-030 start sampled on the first rising edge with rst_n high.

Verification (WIDTH=24)
REQ-031 Reset release, no start -> all outputs 0 for 10 cycles.
REQ-032 ADD A=0xFFFFFF,B=0x000001 -> next cycle done=1, C_bus=0x000000, Z=1, CY=1, N=0; then SUB A=5,B=7 -> C_bus=0xFFFFFE, CY=1, N=1, Z=0.
REQ-033 MUL A=0x001000,B=0x000010 -> busy=1 for 24 cycles, done after E24, C_bus=0x010000, V=0; start(ADD) issued mid-MUL ignored (single done pulse).
REQ-034 MUL A=0x100000,B=0x000020 -> C_bus=0x000000, Z=1, V=1; following PASSBTOC B=0x123456 -> C_bus=0x123456, V=0.
REQ-035 SHL A=0x000001,B=23 -> C_bus=0x800000, N=1; SHL B=30 -> C_bus=0, Z=1; RSHFT4 A=0xABCDEF -> 0x0ABCDE; oper=15 -> C_bus=0, flags 0.
REQ-036 rst_n low at E10 of a MUL -> outputs 0 immediately, no done; restart MUL 3*4 -> C_bus=0x00000C after 24 cycles.
